// File: rtl/mult_rr_sched.sv
// Round-robin front end that shares one pipelined unsigned multiplier between NREQ
// requesters; results come back in acceptance order, tagged with the requester index.
module mult_rr_sched #(
  parameter int WIREWIDTH = 7,
  parameter int NREQ      = 4,
  parameter int LATENCY   = 2,
  parameter int IDW       = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NREQ-1:0]               req,
  input  logic [NREQ*(WIREWIDTH+1)-1:0] x_bus,
  input  logic [NREQ*(WIREWIDTH+1)-1:0] y_bus,
  input  logic                          stall,
  output logic [NREQ-1:0]               gnt,
  output logic [2*WIREWIDTH+1:0]        res,
  output logic                          res_valid,
  output logic [IDW-1:0]                res_id,
  output logic                          busy
);

  localparam int          OPW = WIREWIDTH + 1;
  localparam int          PW  = 2 * OPW;
  localparam int unsigned NR  = NREQ;
  // Product pipe length; its last entry is the output register.
  localparam int          NP  = (LATENCY > 1) ? LATENCY - 1 : 1;

  if (NREQ < 2 || NREQ > 8) begin : g_chk_nreq
    $error("mult_rr_sched: NREQ must be in 2..8");
  end
  if (NREQ > (2 ** IDW)) begin : g_chk_idw
    $error("mult_rr_sched: IDW too narrow for NREQ");
  end
  if (LATENCY < 1) begin : g_chk_lat
    $error("mult_rr_sched: LATENCY must be >= 1");
  end

  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [NREQ-1:0] gnt_c;
  logic            gnt_any;
  logic [IDW-1:0]  gnt_idx;
  int unsigned     cand;
  logic [OPW-1:0]  sel_x, sel_y;

  always_comb begin : arb
    gnt_c   = '0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = 0;
    if (rst_n && !stall) begin
      for (int unsigned k = 0; k < NR; k++) begin
        cand = (32'(ptr_q) + k) % NR;
        if (!gnt_any && req[cand]) begin
          gnt_any     = 1'b1;
          gnt_idx     = IDW'(cand);
          gnt_c[cand] = 1'b1;
        end
      end
    end
    ptr_d = ptr_q;
    if (gnt_any) begin
      ptr_d = IDW'((32'(gnt_idx) + 1) % NR);
    end
    sel_x = x_bus[32'(gnt_idx)*OPW +: OPW];
    sel_y = y_bus[32'(gnt_idx)*OPW +: OPW];
  end

  assign gnt = gnt_c;

  logic           feed_v;
  logic [IDW-1:0] feed_tag;
  logic [PW-1:0]  feed_prod;
  logic           busy_op;

  if (LATENCY == 1) begin : g_direct
    always_comb begin
      feed_v    = gnt_any;
      feed_tag  = gnt_idx;
      feed_prod = PW'(sel_x) * PW'(sel_y);
      busy_op   = 1'b0;
    end
  end else begin : g_opstage
    // Operands are registered first so the arbiter mux and the multiplier sit in separate cycles.
    logic           op_v_q, op_v_d;
    logic [OPW-1:0] op_x_q, op_x_d, op_y_q, op_y_d;
    logic [IDW-1:0] op_tag_q, op_tag_d;

    always_comb begin
      op_v_d   = op_v_q;
      op_x_d   = op_x_q;
      op_y_d   = op_y_q;
      op_tag_d = op_tag_q;
      if (!stall) begin
        op_v_d = gnt_any;
        if (gnt_any) begin
          op_x_d   = sel_x;
          op_y_d   = sel_y;
          op_tag_d = gnt_idx;
        end
      end
      feed_v    = op_v_q;
      feed_tag  = op_tag_q;
      feed_prod = PW'(op_x_q) * PW'(op_y_q);
      busy_op   = op_v_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        op_v_q   <= 1'b0;
        op_x_q   <= '0;
        op_y_q   <= '0;
        op_tag_q <= '0;
      end else begin
        op_v_q   <= op_v_d;
        op_x_q   <= op_x_d;
        op_y_q   <= op_y_d;
        op_tag_q <= op_tag_d;
      end
    end
  end

  logic           pv_q [NP];
  logic           pv_d [NP];
  logic [IDW-1:0] pt_q [NP];
  logic [IDW-1:0] pt_d [NP];
  logic [PW-1:0]  pp_q [NP];
  logic [PW-1:0]  pp_d [NP];
  logic           busy_any;

  // Data only moves with a valid token, so the output register keeps its last result across bubbles.
  always_comb begin : pipe_next
    pv_d = pv_q;
    pt_d = pt_q;
    pp_d = pp_q;
    if (!stall) begin
      pv_d[0] = feed_v;
      if (feed_v) begin
        pt_d[0] = feed_tag;
        pp_d[0] = feed_prod;
      end
      for (int unsigned s = 1; s < NP; s++) begin
        pv_d[s] = pv_q[s-1];
        if (pv_q[s-1]) begin
          pt_d[s] = pt_q[s-1];
          pp_d[s] = pp_q[s-1];
        end
      end
    end
  end

  always_comb begin : busy_or
    busy_any = busy_op;
    for (int unsigned s = 0; s + 1 < NP; s++) begin
      busy_any = busy_any | pv_q[s];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      for (int unsigned s = 0; s < NP; s++) begin
        pv_q[s] <= 1'b0;
        pt_q[s] <= '0;
        pp_q[s] <= '0;
      end
    end else begin
      ptr_q <= ptr_d;
      for (int unsigned s = 0; s < NP; s++) begin
        pv_q[s] <= pv_d[s];
        pt_q[s] <= pt_d[s];
        pp_q[s] <= pp_d[s];
      end
    end
  end

  assign res       = pp_q[NP-1];
  assign res_id    = pt_q[NP-1];
  assign res_valid = pv_q[NP-1] & ~stall;
  assign busy      = busy_any;

endmodule

// File: tb/tb_mult_rr_sched.sv
// Directed plus randomized bench for mult_rr_sched, checked against an age-based
// scoreboard of accepted operations.
module tb_mult_rr_sched;

  localparam int WW  = 7;
  localparam int NR  = 3;
  localparam int LAT = 2;
  localparam int IDW = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  req;
  logic [23:0] x_bus, y_bus;
  logic        stall;
  logic [2:0]  gnt;
  logic [15:0] res;
  logic        res_valid;
  logic [1:0]  res_id;
  logic        busy;

  mult_rr_sched #(.WIREWIDTH(WW), .NREQ(NR), .LATENCY(LAT), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .x_bus(x_bus), .y_bus(y_bus), .stall(stall),
    .gnt(gnt), .res(res), .res_valid(res_valid), .res_id(res_id), .busy(busy)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  int unsigned xo [NR];
  int unsigned yo [NR];

  // Reference: every accepted op carries its age in unstalled edges; it is
  // presented at age LAT and retired after that.
  int          ptr_m;
  int unsigned q_id [$];
  int unsigned q_prod [$];
  int unsigned q_age [$];
  int unsigned last_res, last_id;

  logic [2:0]  g_o;
  logic        v_o;
  logic [1:0]  id_o;
  logic [15:0] r_o;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [2:0] model_gnt(input logic [2:0] r, input logic s);
    if (s) return 3'b000;
    for (int k = 0; k < NR; k++) begin
      int idx;
      idx = (ptr_m + k) % NR;
      if (r[idx]) return 3'(1 << idx);
    end
    return 3'b000;
  endfunction

  task automatic model_reset();
    ptr_m = 0;
    q_id.delete();
    q_prod.delete();
    q_age.delete();
    last_res = 0;
    last_id  = 0;
  endtask

  task automatic model_edge(input logic [2:0] r, input logic s);
    logic [2:0] g;
    g = model_gnt(r, s);
    if (s) return;
    foreach (q_age[i]) q_age[i] = q_age[i] + 1;
    while (q_age.size() > 0 && q_age[0] > LAT) begin
      void'(q_id.pop_front());
      void'(q_prod.pop_front());
      void'(q_age.pop_front());
    end
    for (int i = 0; i < NR; i++) begin
      if (g[i]) begin
        q_id.push_back(i);
        q_prod.push_back(xo[i] * yo[i]);
        q_age.push_back(1);
        ptr_m = (i + 1) % NR;
      end
    end
    foreach (q_age[i]) begin
      if (q_age[i] == LAT) begin
        last_res = q_prod[i];
        last_id  = q_id[i];
      end
    end
  endtask

  task automatic cyc(input logic [2:0] r, input logic s);
    logic [2:0] g_e;
    logic       rv_e, busy_e;
    req   = r;
    stall = s;
    for (int i = 0; i < NR; i++) begin
      x_bus[i*8 +: 8] = 8'(xo[i]);
      y_bus[i*8 +: 8] = 8'(yo[i]);
    end
    #1;
    g_e    = model_gnt(r, s);
    rv_e   = 1'b0;
    busy_e = 1'b0;
    foreach (q_age[i]) begin
      if (q_age[i] == LAT) rv_e = !s;
      if (q_age[i] < LAT) busy_e = 1'b1;
    end
    chk("gnt", 32'(gnt), 32'(g_e));
    chk("res_valid", 32'(res_valid), 32'(rv_e));
    chk("res", 32'(res), last_res);
    chk("res_id", 32'(res_id), last_id);
    chk("busy", 32'(busy), 32'(busy_e));
    g_o  = gnt;
    v_o  = res_valid;
    id_o = res_id;
    r_o  = res;
    @(posedge clk);
    model_edge(r, s);
    for (int i = 0; i < NR; i++) begin
      if (g_e[i]) begin
        xo[i] = $urandom_range(0, 255);
        yo[i] = $urandom_range(0, 255);
      end
    end
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(3'b000, 1'b0);
  endtask

  initial begin
    logic [2:0] pend;
    logic [2:0] rr;
    rst_n = 1'b0;
    req   = 3'b111;
    stall = 1'b0;
    x_bus = '0;
    y_bus = '0;
    for (int i = 0; i < NR; i++) begin
      xo[i] = $urandom_range(0, 255);
      yo[i] = $urandom_range(0, 255);
    end
    model_reset();

    #12;
    chk("rst_gnt", 32'(gnt), 32'(0));
    chk("rst_res_valid", 32'(res_valid), 32'(0));
    chk("rst_res", 32'(res), 32'(0));
    chk("rst_res_id", 32'(res_id), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    rst_n = 1'b1;

    // Single request from requester 1
    xo[1] = 12; yo[1] = 10;
    cyc(3'b010, 1'b0);
    chk("single_gnt", 32'(g_o), 32'(3'b010));
    cyc(3'b000, 1'b0);
    cyc(3'b000, 1'b0);
    chk("single_rv", 32'(v_o), 32'(1));
    chk("single_res", 32'(r_o), 32'd120);
    chk("single_id", 32'(id_o), 32'(1));

    // Full-width product and zero operand
    xo[0] = 255; yo[0] = 255;
    cyc(3'b001, 1'b0);
    xo[2] = 0; yo[2] = 200;
    cyc(3'b100, 1'b0);
    cyc(3'b000, 1'b0);
    chk("full_res", 32'(r_o), 32'h0000_FE01);
    cyc(3'b000, 1'b0);
    chk("zero_res", 32'(r_o), 32'(0));
    chk("zero_id", 32'(id_o), 32'(2));
    idle(1);

    // All three requesting for six cycles
    for (int i = 0; i < 8; i++) begin
      cyc((i < 6) ? 3'b111 : 3'b000, 1'b0);
      if (i < 6) chk("rr_gnt", 32'(g_o), 32'(1 << (i % 3)));
      if (i >= 2) begin
        chk("rr_rv", 32'(v_o), 32'(1));
        chk("rr_id", 32'(id_o), 32'((i - 2) % 3));
      end
    end
    idle(1);

    // Pointer persists across idle cycles
    cyc(3'b100, 1'b0);
    idle(3);
    cyc(3'b011, 1'b0);
    chk("ptr_keep_gnt", 32'(g_o), 32'(3'b001));
    cyc(3'b010, 1'b0);
    chk("ptr_next_gnt", 32'(g_o), 32'(3'b010));
    idle(3);

    // Stall with two operations in flight
    cyc(3'b001, 1'b0);
    cyc(3'b010, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc(3'b100, 1'b1);
      chk("stall_gnt", 32'(g_o), 32'(0));
      chk("stall_rv", 32'(v_o), 32'(0));
    end
    cyc(3'b100, 1'b0);
    chk("unstall_rv0", 32'(v_o), 32'(1));
    chk("unstall_id0", 32'(id_o), 32'(0));
    chk("unstall_gnt", 32'(g_o), 32'(3'b100));
    cyc(3'b000, 1'b0);
    chk("unstall_rv1", 32'(v_o), 32'(1));
    chk("unstall_id1", 32'(id_o), 32'(1));
    idle(3);

    // Asynchronous reset with operations in flight
    cyc(3'b001, 1'b0);
    cyc(3'b010, 1'b0);
    req = 3'b111;
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_gnt", 32'(gnt), 32'(0));
    chk("midrst_rv", 32'(res_valid), 32'(0));
    chk("midrst_res", 32'(res), 32'(0));
    chk("midrst_id", 32'(res_id), 32'(0));
    chk("midrst_busy", 32'(busy), 32'(0));
    #1 rst_n = 1'b1;
    model_reset();
    cyc(3'b111, 1'b0);
    chk("postrst_gnt0", 32'(g_o), 32'(3'b001));
    chk("postrst_rv", 32'(v_o), 32'(0));
    cyc(3'b110, 1'b0);
    chk("postrst_gnt1", 32'(g_o), 32'(3'b010));
    cyc(3'b100, 1'b0);
    chk("postrst_gnt2", 32'(g_o), 32'(3'b100));
    idle(3);

    // Random traffic; a requester holds req until it is granted
    pend = 3'b000;
    for (int n = 0; n < 120; n++) begin
      rr = pend | 3'($urandom_range(0, 7));
      cyc(rr, ($urandom_range(0, 4) == 0));
      pend = rr & ~g_o;
    end
    idle(4);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
